tpu_sequencer: RTL and testbench

Job sequencer for the TPU compute datapath. Once both operand buffers are loaded, it runs one matrix multiply. It clears the systolic array, then streams the A-deep operand vectors out of buffer A and buffer B through the skew delays. It waits for the array pipeline to flush, then drains all N×M results through the PISO under a valid/ready handshake. It sits beside the load controller and owns the buffer read ports and PISO select lines during the compute and drain phases.

---
 rtl/tpu_sequencer.sv | 119 +++++++++++
 tb/tb_tpu_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tpu_sequencer.sv
// Job sequencer for the systolic matmul datapath: clear the array, feed A-deep
// operand vectors, wait LAT flush cycles, then drain N*M results through the PISO.
module tpu_sequencer #(
  parameter int A   = 4,
  parameter int M   = 4,
  parameter int N   = 4,
  parameter int LAT = N + M
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        array_clr,
  output logic        rd_en,
  output logic [15:0] sel_a,
  output logic        send,
  output logic [7:0]  selO_n,
  output logic [7:0]  selO_m,
  output logic        out_valid
);
  localparam int FW = $clog2(LAT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_t;

  state_t        state;
  logic [FW-1:0] flushCnt;

  // sel_a and selO_n/selO_m are the feed and drain counters themselves; they are
  // zeroed on phase exit so they read 0 everywhere outside their own phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flushCnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      array_clr <= 1'b0;
      rd_en     <= 1'b0;
      sel_a     <= '0;
      send      <= 1'b0;
      selO_n    <= '0;
      selO_m    <= '0;
      out_valid <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      array_clr <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        flushCnt  <= '0;
        busy      <= 1'b0;
        rd_en     <= 1'b0;
        sel_a     <= '0;
        send      <= 1'b0;
        selO_n    <= '0;
        selO_m    <= '0;
        out_valid <= 1'b0;
      end else begin
        if (start && state != IDLE) err <= 1'b1;
        case (state)
          IDLE: if (start) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            array_clr <= 1'b1;
          end
          CLEAR: begin
            state <= FEED;
            rd_en <= 1'b1;
            sel_a <= '0;
          end
          FEED: if (sel_a == 16'(A - 1)) begin
            state    <= FLUSH;
            rd_en    <= 1'b0;
            sel_a    <= '0;
            flushCnt <= '0;
          end else begin
            sel_a <= sel_a + 16'd1;
          end
          FLUSH: if (flushCnt == FW'(LAT - 1)) begin
            state     <= DRAIN;
            flushCnt  <= '0;
            send      <= 1'b1;
            out_valid <= 1'b1;
            selO_n    <= '0;
            selO_m    <= '0;
          end else begin
            flushCnt <= flushCnt + 1'b1;
          end
          // out_valid is high for the whole phase, so out_ready alone marks acceptance.
          DRAIN: if (out_ready) begin
            if (selO_m == 8'(M - 1)) begin
              selO_m <= '0;
              if (selO_n == 8'(N - 1)) begin
                state     <= DONE;
                selO_n    <= '0;
                send      <= 1'b0;
                out_valid <= 1'b0;
                done      <= 1'b1;
              end else begin
                selO_n <= selO_n + 8'd1;
              end
            end else begin
              selO_m <= selO_m + 8'd1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer: a job-timeline model predicts every output
// each cycle, and a beat queue filled at job start is popped on each accepted beat.
module tb_tpu_sequencer;
  localparam int A0 = 4, M0 = 4, N0 = 4, L0 = 8;
  localparam int A1 = 1, M1 = 1, N1 = 1, L1 = 1;

  typedef struct packed {
    logic busy, done, clr, rd, send, ov;
    logic [15:0] sa;
    logic [7:0]  n, m;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic busy, done, err, array_clr, rd_en, send, out_valid;
  logic [15:0] sel_a;
  logic [7:0]  selO_n, selO_m;

  logic cStart = 1'b0;
  logic cBusy, cDone, cErr, cClr, cRd, cSend, cOv;
  logic [15:0] cSelA;
  logic [7:0]  cSelN, cSelM;

  int nVec = 0, nMis = 0;

  // model state for the main instance
  bit mAct = 1'b0;
  bit errExp = 1'b0;
  int mOff = 0, mAcc = 0;
  int beatQ[$];

  always #5 clk = ~clk;

  tpu_sequencer #(.A(A0), .M(M0), .N(N0), .LAT(L0)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .array_clr(array_clr), .rd_en(rd_en),
    .sel_a(sel_a), .send(send), .selO_n(selO_n), .selO_m(selO_m), .out_valid(out_valid)
  );

  tpu_sequencer #(.A(A1), .M(M1), .N(N1), .LAT(L1)) dutCorner (
    .clk(clk), .rst(rst), .start(cStart), .abort(1'b0), .out_ready(1'b1),
    .busy(cBusy), .done(cDone), .err(cErr), .array_clr(cClr), .rd_en(cRd),
    .sel_a(cSelA), .send(cSend), .selO_n(cSelN), .selO_m(cSelM), .out_valid(cOv)
  );

  // Expected outputs of an active job, off cycles after start was sampled, with
  // acc beats already accepted.
  function automatic expT expOut(int a, int mm, int nn, int lat, int off, int acc);
    expT e;
    e = '0;
    e.busy = 1'b1;
    if (off == 1) e.clr = 1'b1;
    else if (off <= a + 1) begin
      e.rd = 1'b1;
      e.sa = 16'(off - 2);
    end else if (off > a + lat + 1) begin
      if (acc < nn * mm) begin
        e.send = 1'b1;
        e.ov   = 1'b1;
        e.n    = 8'(acc / mm);
        e.m    = 8'(acc % mm);
      end else e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic expT actMain();
    expT v;
    v.busy = busy; v.done = done; v.clr = array_clr; v.rd = rd_en;
    v.send = send; v.ov = out_valid; v.sa = sel_a; v.n = selO_n; v.m = selO_m;
    return v;
  endfunction

  function automatic expT actCorner();
    expT v;
    v.busy = cBusy; v.done = cDone; v.clr = cClr; v.rd = cRd;
    v.send = cSend; v.ov = cOv; v.sa = cSelA; v.n = cSelN; v.m = cSelM;
    return v;
  endfunction

  task automatic chk(input string name, input expT act, input expT exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s t=%0t got=%h want=%h (busy,done,clr,rd,send,ov,sa,n,m)",
               name, $time, act, exp);
    end
  endtask

  task automatic chkBit(input string name, input logic act, input logic exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle, compare, then advance the model by one edge.
  always @(negedge clk) begin
    expT ev;
    int beat;
    bit wasDone;
    if (!rst) begin
      chk("reset_out", actMain(), '0);
      chkBit("reset_err", err, 1'b0);
      mAct = 1'b0;
      errExp = 1'b0;
      beatQ.delete();
    end else begin
      ev = mAct ? expOut(A0, M0, N0, L0, mOff, mAcc) : '0;
      chk("outputs", actMain(), ev);
      chkBit("err", err, errExp);
      if (out_valid && out_ready) begin
        nVec++;
        if (beatQ.size() == 0) begin
          nMis++;
          $display("FAIL beat t=%0t got=(%0d,%0d) want=none", $time, selO_n, selO_m);
        end else begin
          beat = beatQ.pop_front();
          if ({selO_n, selO_m} !== 16'(beat)) begin
            nMis++;
            $display("FAIL beat t=%0t got=(%0d,%0d) want=(%0d,%0d)", $time,
                     selO_n, selO_m, beat / 256, beat % 256);
          end
        end
      end
      wasDone = mAct && (mOff > A0 + L0 + 1) && (mAcc == N0 * M0);
      errExp = !abort && start && mAct;
      if (abort) begin
        mAct = 1'b0;
        beatQ.delete();
      end else if (mAct) begin
        if (wasDone) mAct = 1'b0;
        else begin
          if (mOff > A0 + L0 + 1 && out_ready) mAcc++;
          mOff++;
        end
      end else if (start) begin
        mAct = 1'b1;
        mOff = 1;
        mAcc = 0;
        for (int r = 0; r < N0; r++)
          for (int c = 0; c < M0; c++) beatQ.push_back(r * 256 + c);
      end
    end
  end

  task automatic drive(input bit s, input bit ab, input bit rdy);
    start = s; abort = ab; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("reset_async", actMain(), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) drive(0, 0, 1);

    // nominal job
    drive(1, 0, 1);
    repeat (35) drive(0, 0, 1);

    // backpressure on beats (1,2) x3 and (3,3) x1
    for (int i = 0; i < 40; i++) drive(i == 0, 0, !(i inside {20, 21, 22, 32}));

    // stray starts during FEED and DONE
    for (int i = 0; i < 36; i++) drive(i == 0 || i == 5 || i == 30, 0, 1);

    // abort in FLUSH, then a fresh job
    for (int i = 0; i < 50; i++) drive(i == 0 || i == 12, i == 10, 1);

    // abort and start together while idle
    drive(1, 1, 1);
    repeat (3) drive(0, 0, 1);

    // randomized jobs with random backpressure, stray starts and rare aborts
    for (int j = 0; j < 8; j++) begin
      drive(1, 0, 1);
      for (int i = 1; i < 70; i++)
        drive(($urandom % 20) == 0, ($urandom % 300) == 0, ($urandom % 4) != 0);
    end
    repeat (40) drive(0, 0, 1);

    // async reset in the middle of DRAIN, between clock edges
    drive(1, 0, 1);
    repeat (16) drive(0, 0, 1);
    #2 rst = 1'b0;
    #1;
    chk("reset_middrain", actMain(), '0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) drive(0, 0, 1);
    drive(1, 0, 1);
    repeat (35) drive(0, 0, 1);

    // single-element corner instance: done lands 5 cycles after start
    cStart = 1'b1;
    @(posedge clk); #1;
    cStart = 1'b0;
    for (int off = 1; off <= 7; off++) begin
      expT ce;
      #3;
      if (off <= A1 + L1 + 2 + N1 * M1)
        ce = expOut(A1, M1, N1, L1, off, (off >= A1 + L1 + 2) ? off - (A1 + L1 + 2) : 0);
      else ce = '0;
      chk("corner", actCorner(), ce);
      chkBit("corner_err", cErr, 1'b0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
